// File: rtl/dmem_pkg.sv
// Shared encodings for data_mem_ctrl: access sizes, FSM states and lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. DATA_MEM_CTRL_CLEAR_EN adds the CLEAR state.
package dmem_pkg;

    // Access size as carried on req_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

`ifdef DATA_MEM_CTRL_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;
`endif

    // True when the size/lane pair cannot be served (misaligned or reserved size)
    function automatic logic bad_align(input size_e sz, input logic [1:0] lane);
        logic r;
        case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lane[0];
            SZ_WORD: r = |lane;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Byte-lane write enables for a store of the given size at the given lane
    function automatic logic [3:0] store_be(input size_e sz, input logic [1:0] lane);
        logic [3:0] r;
        case (sz)
            SZ_BYTE: r = 4'b0001 << lane;
            SZ_HALF: r = lane[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Replicate right-aligned store data across lanes; the byte enables pick the lane
    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of a memory word and sign- or zero-extend it
    function automatic logic [31:0] load_extend(input size_e sz, input logic [1:0] lane,
                                                input logic uns, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Latency: read data valid the cycle after an enabled read edge.
// Backpressure: none; one access per cycle when en is high.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Byte-masked write or registered read on an enabled edge
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller in front of a byte-enabled data RAM with programmable wait states.
// Latency: rsp_valid WAIT_STATES+1 cycles after accept (1 cycle for errors); one request per WAIT_STATES+2 cycles.
// Backpressure: req_ready high only while idle; DATA_MEM_CTRL_CLEAR_EN zeroes the RAM after reset first.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

`ifdef DATA_MEM_CTRL_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // Request fields captured at the accept edge
    logic                  we_q;
    logic                  err_q;
    logic                  uns_q;
    size_e                 size_q;
    logic [1:0]            lane_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdat_q;

    // Live decode of the incoming request
    size_e req_sz;
    logic  req_oor;
    logic  req_err;
    logic  accept;

    // RAM port
    logic                  ram_en;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    assign req_sz  = size_e'(req_size);
    assign req_oor = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign req_err = bad_align(req_sz, req_addr[1:0]) | req_oor;
    assign accept  = req_ready & req_valid;

`ifdef DATA_MEM_CTRL_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt;

    // Walk every word address once while clearing
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`endif

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request so later req_* changes cannot disturb it
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            lane_q  <= 2'd0;
            waddr_q <= '0;
            be_q    <= 4'd0;
            wdat_q  <= 32'd0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= req_err;
            uns_q   <= req_unsigned;
            size_q  <= req_sz;
            lane_q  <= req_addr[1:0];
            waddr_q <= req_addr[ADDR_WIDTH+1:2];
            be_q    <= store_be(req_sz, req_addr[1:0]);
            wdat_q  <= store_data(req_sz, req_wdata);
        end
    end

    // Next state, RAM strobe on the edge entering RESP, and response outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        ram_en    = 1'b0;
        ram_we    = we_q;
        ram_be    = be_q;
        ram_addr  = waddr_q;
        ram_wdata = wdat_q;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                // With zero wait states the access shares the accept edge,
                // so the RAM is fed straight from the request pins.
                ram_we    = req_we;
                ram_be    = store_be(req_sz, req_addr[1:0]);
                ram_addr  = req_addr[ADDR_WIDTH+1:2];
                ram_wdata = store_data(req_sz, req_wdata);
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = ST_RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = ST_RESP;
                        ram_en    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_RESP;
                    ram_en    = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
`ifdef DATA_MEM_CTRL_CLEAR_EN
            ST_CLEAR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_be    = 4'b1111;
                ram_addr  = clr_cnt;
                ram_wdata = 32'd0;
                if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Reset wins over everything: no handshake, no response, no pending RAM write
        if (reset) begin
            req_ready = 1'b0;
            ram_en    = 1'b0;
        end
        rsp_valid = (state == ST_RESP) && !reset;
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q && !we_q) ?
                    load_extend(size_q, lane_q, uns_q, ram_rdata) : 32'd0;
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
